// File: rtl/snes_poller_if.sv
// Bus bundle between the game-pad poller and its consumer.
// The master side is the poller: it drives the pad protocol lines and the published button words.
interface snes_poller_if #(
   parameter int NUM_CH   = 1,
   parameter int NUM_BITS = 12
);
   logic                         enable;
   logic [NUM_CH-1:0]            serial_data;
   logic                         snes_clk;
   logic                         data_latch;
   logic [NUM_CH*NUM_BITS-1:0]   buttons;
   logic [NUM_CH*NUM_BITS-1:0]   pressed;
   logic [NUM_CH*NUM_BITS-1:0]   released;
   logic                         valid;

   modport master (
      input  enable, serial_data,
      output snes_clk, data_latch, buttons, pressed, released, valid
   );

   modport slave (
      output enable, serial_data,
      input  snes_clk, data_latch, buttons, pressed, released, valid
   );
endinterface

// File: rtl/snes_poller.sv
// Serial game-pad poller: generates the shared latch/clock pad protocol, shifts in NUM_CH pads
// in parallel and publishes active-high button words with pressed/released edges.
module snes_poller #(
   parameter int CLK_DIV     = 21,
   parameter int NUM_BITS    = 12,
   parameter int NUM_CH      = 1,
   parameter int LATCH_TICKS = 2,
   parameter int POLL_TICKS  = 16000
) (
   input logic           clk,
   input logic           reset,
   snes_poller_if.master bus
);
   localparam int W  = NUM_CH * NUM_BITS;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = $clog2(POLL_TICKS + 1);
   localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_div;
   logic [IW-1:0]   r_idle, w_idle_nxt;
   logic [LW-1:0]   r_lcnt, w_lcnt_nxt;
   logic [BW-1:0]   r_bit, w_bit_nxt;
   logic            r_phase, w_phase_nxt;
   logic [W-1:0]    r_shift, w_shift_nxt;
   logic            r_sclk, w_sclk_nxt;
   logic            r_latch, w_latch_nxt;
   logic [W-1:0]    r_buttons, r_pressed, r_released;
   logic            r_valid;
   logic            w_tick, w_upd;

   assign w_tick = (r_div == DW'(CLK_DIV - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle;
      w_lcnt_nxt  = r_lcnt;
      w_bit_nxt   = r_bit;
      w_phase_nxt = r_phase;
      w_shift_nxt = r_shift;
      w_sclk_nxt  = r_sclk;
      w_latch_nxt = 1'b0;
      w_upd       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_sclk_nxt = 1'b1;
            if (w_tick) begin
               // Once the poll interval has elapsed the count saturates until enable allows a frame.
               if (r_idle >= IW'(POLL_TICKS - 1)) begin
                  if (bus.enable) begin
                     w_state_nxt = S_LATCH;
                     w_idle_nxt  = '0;
                     w_lcnt_nxt  = '0;
                     w_latch_nxt = 1'b1;
                  end else begin
                     w_idle_nxt  = IW'(POLL_TICKS);
                  end
               end else begin
                  w_idle_nxt = r_idle + IW'(1);
               end
            end
         end
         S_LATCH: begin
            w_latch_nxt = 1'b1;
            if (w_tick) begin
               if (r_lcnt == LW'(LATCH_TICKS - 1)) begin
                  w_state_nxt = S_SHIFT;
                  w_latch_nxt = 1'b0;
                  w_bit_nxt   = '0;
                  w_phase_nxt = 1'b0;
               end else begin
                  w_lcnt_nxt = r_lcnt + LW'(1);
               end
            end
         end
         S_SHIFT: begin
            if (w_tick) begin
               if (!r_phase) begin
                  for (int unsigned c = 0; c < NUM_CH; c++)
                     w_shift_nxt[c*NUM_BITS + int'(r_bit)] = bus.serial_data[c];
                  w_sclk_nxt  = 1'b0;
                  w_phase_nxt = 1'b1;
               end else begin
                  w_sclk_nxt = 1'b1;
                  if (r_bit == BW'(NUM_BITS - 1)) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_bit_nxt   = r_bit + BW'(1);
                     w_phase_nxt = 1'b0;
                  end
               end
            end
         end
         S_DONE: begin
            w_upd       = 1'b1;
            w_state_nxt = S_IDLE;
            w_idle_nxt  = '0;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_idle  <= '0;
         r_lcnt  <= '0;
         r_bit   <= '0;
         r_phase <= 1'b0;
         r_shift <= '0;
         r_sclk  <= 1'b1;
         r_latch <= 1'b0;
      end else begin
         // The divider holds during the single DONE cycle so each frame adds exactly one clk.
         if (r_state != S_DONE)
            r_div <= w_tick ? '0 : r_div + DW'(1);
         r_state <= w_state_nxt;
         r_idle  <= w_idle_nxt;
         r_lcnt  <= w_lcnt_nxt;
         r_bit   <= w_bit_nxt;
         r_phase <= w_phase_nxt;
         r_shift <= w_shift_nxt;
         r_sclk  <= w_sclk_nxt;
         r_latch <= w_latch_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buttons  <= '0;
         r_pressed  <= '0;
         r_released <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= w_upd;
         if (w_upd) begin
            r_buttons  <= ~r_shift;
            r_pressed  <= ~r_shift & ~r_buttons;
            r_released <= r_shift & r_buttons;
         end
      end
   end

   assign bus.snes_clk   = r_sclk;
   assign bus.data_latch = r_latch;
   assign bus.buttons    = r_buttons;
   assign bus.pressed    = r_pressed;
   assign bus.released   = r_released;
   assign bus.valid      = r_valid;
endmodule

// File: tb/tb_snes_poller.sv
// Directed bench for snes_poller with a behavioural shift-register pad model per channel.
module tb_snes_poller;
   localparam int CLK_DIV     = 2;
   localparam int NUM_BITS    = 4;
   localparam int NUM_CH      = 2;
   localparam int LATCH_TICKS = 2;
   localparam int POLL_TICKS  = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   logic [NUM_BITS-1:0] pad_state [NUM_CH];
   int                  pad_idx = 0;
   logic [NUM_CH-1:0]   pad_line;

   snes_poller_if #(.NUM_CH(NUM_CH), .NUM_BITS(NUM_BITS)) bus ();

   snes_poller #(
      .CLK_DIV(CLK_DIV), .NUM_BITS(NUM_BITS), .NUM_CH(NUM_CH),
      .LATCH_TICKS(LATCH_TICKS), .POLL_TICKS(POLL_TICKS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pad: latch reloads to bit 0, each snes_clk rise advances; lines are active-low.
   always @(posedge bus.data_latch or posedge bus.snes_clk) begin
      if (bus.data_latch) pad_idx <= 0;
      else                pad_idx <= pad_idx + 1;
   end

   always_comb begin
      pad_line = '1;
      for (int c = 0; c < NUM_CH; c++)
         pad_line[c] = (pad_idx < NUM_BITS) ? ~pad_state[c][pad_idx[1:0]] : 1'b1;
   end
   assign bus.serial_data = pad_line;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_latch(output int n);
      n = 0;
      do begin step(); n++; end while (!bus.data_latch && n < 400);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin step(); n++; end while (!bus.valid && n < 200);
   endtask

   task automatic frame_check(input string tag, input logic [7:0] eb, input logic [7:0] ep,
                              input logic [7:0] er, output int t0);
      int lat, nlow, wmin, wmax, vw, run, guard;
      logic [7:0] b, p, r;
      t0 = cyc;
      lat = 1; nlow = 0; wmin = 999; wmax = 0; vw = 0; run = 0; guard = 0;
      b = '0; p = '0; r = '0;
      step();
      while (bus.data_latch && lat < 50) begin lat++; step(); end
      while (!bus.valid && guard < 100) begin
         if (!bus.snes_clk) run++;
         else if (run > 0) begin
            nlow++;
            if (run < wmin) wmin = run;
            if (run > wmax) wmax = run;
            run = 0;
         end
         step();
         guard++;
      end
      b = bus.buttons; p = bus.pressed; r = bus.released;
      while (bus.valid && vw < 10) begin vw++; step(); end
      check({tag, " latch_clks"}, lat, 4);
      check({tag, " clk_pulses"}, nlow, NUM_BITS);
      check({tag, " pulse_wmin"}, wmin, CLK_DIV);
      check({tag, " pulse_wmax"}, wmax, CLK_DIV);
      check({tag, " valid_width"}, vw, 1);
      check({tag, " buttons"}, b, eb);
      check({tag, " pressed"}, p, ep);
      check({tag, " released"}, r, er);
   endtask

   initial begin
      int n, tA, tB, tC, tE, tG, seen;
      pad_state[0] = 4'b0101;
      pad_state[1] = 4'b0000;
      bus.enable = 1'b1;
      reset = 1'b1;
      repeat (3) step();
      @(negedge clk) reset = 1'b0;

      wait_latch(n);
      check("pre_latch_seen", bus.data_latch, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst snes_clk", bus.snes_clk, 1);
      check("async_rst latch", bus.data_latch, 0);
      check("async_rst buttons", bus.buttons, 8'h00);
      check("async_rst valid", bus.valid, 0);
      @(negedge clk) reset = 1'b0;
      wait_latch(n);
      check("rst_to_latch_clks", n, 6);

      frame_check("A", 8'h05, 8'h05, 8'h00, tA);

      pad_state[0] = 4'b1100;
      pad_state[1] = 4'b0001;
      wait_latch(n);
      check("hold_buttons", bus.buttons, 8'h05);
      frame_check("B", 8'h1C, 8'h18, 8'h01, tB);

      wait_latch(n);
      frame_check("C", 8'h1C, 8'h00, 8'h00, tC);
      check("frame_period", tC - tB, 27);

      pad_state[0] = 4'b0011;
      pad_state[1] = 4'b0000;
      wait_latch(n);
      n = 0;
      while (bus.data_latch && n < 50) begin step(); n++; end
      step(); step();
      bus.enable = 1'b0;
      wait_valid(n);
      check("D valid_seen", bus.valid, 1);
      check("D buttons", bus.buttons, 8'h03);
      check("D pressed", bus.pressed, 8'h03);
      check("D released", bus.released, 8'h1C);

      seen = 0;
      repeat (200) begin step(); if (bus.data_latch) seen++; end
      check("disabled_no_latch", seen, 0);

      pad_state[0] = 4'b0101;
      bus.enable = 1'b1;
      wait_latch(n);
      check("restart_on_next_tick", (n >= 1 && n <= CLK_DIV), 1);
      frame_check("E", 8'h05, 8'h04, 8'h02, tE);

      wait_latch(n);
      n = 0;
      while (bus.snes_clk && n < 50) begin step(); n++; end
      check("F in_shift", bus.snes_clk, 0);
      #2 reset = 1'b1;
      #1;
      check("midshift_rst snes_clk", bus.snes_clk, 1);
      check("midshift_rst latch", bus.data_latch, 0);
      check("midshift_rst buttons", bus.buttons, 8'h00);
      check("midshift_rst pressed", bus.pressed, 8'h00);
      check("midshift_rst valid", bus.valid, 0);
      pad_state[0] = 4'b1010;
      pad_state[1] = 4'b0110;
      @(negedge clk) reset = 1'b0;
      wait_latch(n);
      check("rst2_to_latch_clks", n, 6);
      frame_check("G", 8'h6A, 8'h6A, 8'h00, tG);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
